bcd_run_ctrl: RTL and testbench

BCD_RUN_CTRL -- requirements
Module: bcd_run_ctrl

---
 rtl/bcd_run_ctrl_if.sv | 26 ++
 rtl/bcd_run_ctrl.sv | 114 +++++++++++
 tb/tb_bcd_run_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bcd_run_ctrl_if.sv
// Command and status bundle for bcd_run_ctrl: the controller is the slave,
// the block that issues commands and watches the count is the master.
interface bcd_run_ctrl_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] limit;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        tick;
    logic        wrap;
    logic        load_err;

    modport master (
        output start, stop, clear, load, load_val, limit,
        input  count, running, done, tick, wrap, load_err
    );

    modport slave (
        input  start, stop, clear, load, load_val, limit,
        output count, running, done, tick, wrap, load_err
    );
endinterface

// File: rtl/bcd_run_ctrl.sv
// Four-digit BCD run/pause counter with prescaler, terminal-count DONE state,
// and preset load. All outputs are registered.
module bcd_run_ctrl #(
    parameter int unsigned PRESCALE = 10
) (
    input logic          clk,
    input logic          rst,
    bcd_run_ctrl_if.slave bus
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state;
    logic [7:0]  presc;
    logic [15:0] stepped;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_bcd(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign stepped = bcd_inc(bus.count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            presc        <= '0;
            bus.count    <= '0;
            bus.running  <= 1'b0;
            bus.done     <= 1'b0;
            bus.tick     <= 1'b0;
            bus.wrap     <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.tick     <= 1'b0;
            bus.wrap     <= 1'b0;
            bus.load_err <= 1'b0;
            if (bus.clear) begin
                state       <= IDLE;
                presc       <= '0;
                bus.count   <= '0;
                bus.running <= 1'b0;
                bus.done    <= 1'b0;
            end else begin
                case (state)
                    // stop outranks start and load, so it blocks both even though it does nothing here
                    IDLE: begin
                        if (!bus.stop) begin
                            if (bus.start) begin
                                state       <= RUN;
                                presc       <= '0;
                                bus.running <= 1'b1;
                            end else if (bus.load) begin
                                if (is_bcd(bus.load_val)) bus.count    <= bus.load_val;
                                else                      bus.load_err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.stop) begin
                            state       <= PAUSE;
                            bus.running <= 1'b0;
                        end else if (presc == LAST) begin
                            presc     <= '0;
                            bus.count <= stepped;
                            bus.tick  <= 1'b1;
                            bus.wrap  <= (bus.count == 16'h9999);
                            if (stepped == bus.limit && is_bcd(bus.limit)) begin
                                state       <= DONE;
                                bus.running <= 1'b0;
                                bus.done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 8'd1;
                        end
                    end
                    PAUSE: begin
                        if (!bus.stop && bus.start) begin
                            state       <= RUN;
                            bus.running <= 1'b1;
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Scoreboard bench for bcd_run_ctrl with PRESCALE=2; expectations are
// hand-derived per cycle and popped after each rising edge.
module tb_bcd_run_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [15:0] count;
        logic [4:0]  flags;   // {running, done, tick, wrap, load_err}
    } exp_t;

    exp_t sb[$];

    bcd_run_ctrl_if bus ();

    bcd_run_ctrl #(.PRESCALE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.running, bus.done, bus.tick, bus.wrap, bus.load_err};
    endfunction

    // One clock: drive commands, queue what must be seen after the edge, compare.
    task automatic cyc(input string tag, input logic st, input logic sp, input logic cl,
                       input logic ld, input logic [15:0] lv,
                       input logic [15:0] ecount, input logic [4:0] eflags);
        exp_t e;
        @(negedge clk);
        bus.start    = st;
        bus.stop     = sp;
        bus.clear    = cl;
        bus.load     = ld;
        bus.load_val = lv;
        e.count = ecount;
        e.flags = eflags;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_count"}, {16'h0, bus.count}, {16'h0, e.count});
            check_eq({tag, "_flags"}, {27'h0, flags_now()}, {27'h0, e.flags});
        end
    endtask

    localparam logic [4:0] F0   = 5'b00000;
    localparam logic [4:0] FR   = 5'b10000;
    localparam logic [4:0] FRT  = 5'b10100;
    localparam logic [4:0] FRTW = 5'b10110;
    localparam logic [4:0] FD   = 5'b01000;
    localparam logic [4:0] FDT  = 5'b01100;
    localparam logic [4:0] FE   = 5'b00001;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.limit    = 16'hFFFF;
        rst          = 1'b0;
        #23;
        check_eq("reset_count", {16'h0, bus.count}, 32'h0);
        check_eq("reset_flags", {27'h0, flags_now()}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // first steps land two edges after start
        cyc("s_e0", 1, 0, 0, 0, 16'h0, 16'h0000, FR);
        cyc("s_e1", 0, 0, 0, 0, 16'h0, 16'h0000, FR);
        cyc("s_e2", 0, 0, 0, 0, 16'h0, 16'h0001, FRT);
        cyc("s_e3", 0, 0, 0, 0, 16'h0, 16'h0001, FR);
        cyc("s_e4", 0, 0, 0, 0, 16'h0, 16'h0002, FRT);
        cyc("s_stop", 0, 1, 0, 0, 16'h0, 16'h0002, F0);
        cyc("s_clr", 0, 0, 1, 0, 16'h0, 16'h0000, F0);

        // load validation
        cyc("ld_bad", 0, 0, 0, 1, 16'h12A4, 16'h0000, FE);
        cyc("ld_idle", 0, 0, 0, 0, 16'h0, 16'h0000, F0);
        cyc("ld_ok", 0, 0, 0, 1, 16'h1234, 16'h1234, F0);
        cyc("ld_hold", 0, 0, 0, 0, 16'h0, 16'h1234, F0);
        cyc("ld_clr", 0, 0, 1, 0, 16'h0, 16'h0000, F0);

        // wrap through 9999 and stop at limit 0005
        cyc("w_load", 0, 0, 0, 1, 16'h9998, 16'h9998, F0);
        bus.limit = 16'h0005;
        cyc("w_e0", 1, 0, 0, 0, 16'h0, 16'h9998, FR);
        cyc("w_e1", 0, 0, 0, 0, 16'h0, 16'h9998, FR);
        cyc("w_e2", 0, 0, 0, 0, 16'h0, 16'h9999, FRT);
        cyc("w_e3", 0, 0, 0, 0, 16'h0, 16'h9999, FR);
        cyc("w_e4", 0, 0, 0, 0, 16'h0, 16'h0000, FRTW);
        for (int k = 1; k <= 5; k++) begin
            cyc("w_odd", 0, 0, 0, 0, 16'h0, 16'(k - 1), FR);
            cyc("w_step", 0, 0, 0, 0, 16'h0, 16'(k), (k == 5) ? FDT : FRT);
        end
        for (int k = 0; k < 10; k++) begin
            cyc("w_frozen", k[0], ~k[0], 0, 1, 16'h0100, 16'h0005, FD);
        end
        bus.limit = 16'hFFFF;
        cyc("w_clr", 0, 0, 1, 0, 16'h0, 16'h0000, F0);

        // pause on the step edge, resume keeps presc
        cyc("p_e0", 1, 0, 0, 0, 16'h0, 16'h0000, FR);
        cyc("p_e1_ld", 0, 0, 0, 1, 16'h7777, 16'h0000, FR);
        cyc("p_stop", 0, 1, 0, 0, 16'h0, 16'h0000, F0);
        cyc("p_held", 0, 0, 0, 0, 16'h0, 16'h0000, F0);
        cyc("p_resume", 1, 0, 0, 0, 16'h0, 16'h0000, FR);
        cyc("p_step1", 0, 0, 0, 0, 16'h0, 16'h0001, FRT);
        cyc("p_odd", 0, 0, 0, 0, 16'h0, 16'h0001, FR);
        cyc("p_step2", 0, 0, 0, 0, 16'h0, 16'h0002, FRT);

        // all three commands on a would-be step edge: clear wins
        cyc("c_pre", 0, 0, 0, 0, 16'h0, 16'h0002, FR);
        cyc("c_all", 1, 1, 1, 0, 16'h0, 16'h0000, F0);
        cyc("c_idle", 0, 0, 0, 0, 16'h0, 16'h0000, F0);

        // asynchronous reset between edges while counting
        cyc("r_load", 0, 0, 0, 1, 16'h0040, 16'h0040, F0);
        cyc("r_e0", 1, 0, 0, 0, 16'h0, 16'h0040, FR);
        cyc("r_e1", 0, 0, 0, 0, 16'h0, 16'h0040, FR);
        cyc("r_e2", 0, 0, 0, 0, 16'h0, 16'h0041, FRT);
        cyc("r_e3", 0, 0, 0, 0, 16'h0, 16'h0041, FR);
        cyc("r_e4", 0, 0, 0, 0, 16'h0, 16'h0042, FRT);
        #2;
        rst = 1'b0;
        #1;
        check_eq("r_async_count", {16'h0, bus.count}, 32'h0);
        check_eq("r_async_flags", {27'h0, flags_now()}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc("r_after", 0, 0, 0, 0, 16'h0, 16'h0000, F0);
        cyc("r_start", 1, 0, 0, 0, 16'h0, 16'h0000, FR);
        cyc("r_e1b", 0, 0, 0, 0, 16'h0, 16'h0000, FR);
        cyc("r_e2b", 0, 0, 0, 0, 16'h0, 16'h0001, FRT);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
